// File: rtl/alu_issue_stage_if.sv
// Command, alu and result signals of the ALU issue stage, bundled for port connection.
// slave = the issue stage itself, master = the side driving commands and hosting the alu.
interface alu_issue_stage_if #(
  parameter int WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_x;
  logic [WIDTH-1:0] cmd_y;
  logic [1:0]       cmd_cmode;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_x;
  logic [WIDTH-1:0] alu_y;
  logic             alu_c;
  logic [WIDTH-1:0] alu_s;
  logic             alu_cout;
  logic             alu_zero;
  logic             alu_ovf;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_s;
  logic             res_c;
  logic             res_z;
  logic             res_of;
  logic             flag_c;
  logic             busy;

  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_cmode,
    input  alu_s, alu_cout, alu_zero, alu_ovf, res_ready,
    output cmd_ready, alu_op, alu_x, alu_y, alu_c,
    output res_valid, res_s, res_c, res_z, res_of, flag_c, busy
  );

  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_cmode,
    output alu_s, alu_cout, alu_zero, alu_ovf, res_ready,
    input  cmd_ready, alu_op, alu_x, alu_y, alu_c,
    input  res_valid, res_s, res_c, res_z, res_of, flag_c, busy
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Buffers ALU commands in a small FIFO, drives registered alu inputs, samples the alu
// outputs after SETTLE cycles and hands the result downstream; keeps a chained carry flag.
module alu_issue_stage #(
  parameter int WIDTH      = 4,
  parameter int SETTLE     = 1,
  parameter int FIFO_DEPTH = 2
) (
  input logic              clk,
  input logic              rst,
  alu_issue_stage_if.slave bus
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [1:0]       cmode;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, DRIVE, WAIT_OUT} state_t;

  cmd_t             mem_q [FIFO_DEPTH];
  cmd_t             cmd_in, head;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  state_t           state_q, state_d;
  logic [SCW-1:0]   cnt_q, cnt_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic [WIDTH-1:0] alu_x_q, alu_x_d, alu_y_q, alu_y_d;
  logic             alu_c_q, alu_c_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_s_q, res_s_d;
  logic             res_c_q, res_c_d, res_z_q, res_z_d, res_of_q, res_of_d;
  logic             flag_c_q, flag_c_d;
  logic             cmd_ready, push, load, load_c;

  // Ready comes from the registered count only: a full FIFO refuses even if it pops this cycle.
  assign cmd_ready = !rst && (count_q != CW'(FIFO_DEPTH));
  assign push      = bus.cmd_valid && cmd_ready;
  assign cmd_in    = '{op: bus.cmd_op, x: bus.cmd_x, y: bus.cmd_y, cmode: bus.cmd_cmode};
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    load        = 1'b0;
    load_c      = flag_c_q;
    res_valid_d = res_valid_q;
    res_s_d     = res_s_q;
    res_c_d     = res_c_q;
    res_z_d     = res_z_q;
    res_of_d    = res_of_q;
    flag_c_d    = flag_c_q;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          load    = 1'b1;
          state_d = DRIVE;
          cnt_d   = '0;
        end
      end
      DRIVE: begin
        if (cnt_q == SCW'(SETTLE - 1)) begin
          res_s_d     = bus.alu_s;
          res_c_d     = bus.alu_cout;
          res_z_d     = bus.alu_zero;
          res_of_d    = bus.alu_ovf;
          res_valid_d = 1'b1;
          state_d     = WAIT_OUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_OUT: begin
        if (bus.res_ready) begin
          flag_c_d    = res_c_q;
          // Next command of a carry chain sees the carry being retired right now.
          load_c      = res_c_q;
          res_valid_d = 1'b0;
          if (count_q != '0) begin
            load    = 1'b1;
            state_d = DRIVE;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    alu_op_d = alu_op_q;
    alu_x_d  = alu_x_q;
    alu_y_d  = alu_y_q;
    alu_c_d  = alu_c_q;
    if (load) begin
      alu_op_d = head.op;
      alu_x_d  = head.x;
      alu_y_d  = head.y;
      alu_c_d  = (head.cmode == 2'b01) || ((head.cmode == 2'b10) && load_c);
    end

    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(load);
    count_d  = count_q + CW'(push) - CW'(load);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      alu_op_q    <= '0;
      alu_x_q     <= '0;
      alu_y_q     <= '0;
      alu_c_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_s_q     <= '0;
      res_c_q     <= 1'b0;
      res_z_q     <= 1'b0;
      res_of_q    <= 1'b0;
      flag_c_q    <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_op_q    <= alu_op_d;
      alu_x_q     <= alu_x_d;
      alu_y_q     <= alu_y_d;
      alu_c_q     <= alu_c_d;
      res_valid_q <= res_valid_d;
      res_s_q     <= res_s_d;
      res_c_q     <= res_c_d;
      res_z_q     <= res_z_d;
      res_of_q    <= res_of_d;
      flag_c_q    <= flag_c_d;
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.alu_op    = alu_op_q;
  assign bus.alu_x     = alu_x_q;
  assign bus.alu_y     = alu_y_q;
  assign bus.alu_c     = alu_c_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_s     = res_s_q;
  assign bus.res_c     = res_c_q;
  assign bus.res_z     = res_z_q;
  assign bus.res_of    = res_of_q;
  assign bus.flag_c    = flag_c_q;
  assign bus.busy      = (state_q != IDLE) || (count_q != '0);
endmodule
